boreal_stage_scheduler: RTL

Per-frame sequencer for the decode chain: CSP filter, Kalman pair, LMS decoder and symbolic mapper.
- On each frame request it launches the stages strictly in order with one-cycle start pulses and waits for each stage's done before launching the next.
- It watchdogs every stage, reports per-frame latency and counts dropped (overrun) requests for MMIO readback.
- It sits between the frame-synchronisation logic and the intelligence-layer stages, replacing free-running valid chaining.

---
 rtl/boreal_sched_pkg.sv | 31 +++
 rtl/boreal_stage_watchdog.sv | 32 +++
 rtl/boreal_stage_scheduler.sv | 129 ++++++++++++
 3 files changed

// File: rtl/boreal_sched_pkg.sv
// Shared constants and types for the per-frame stage scheduler.
// Holds the state encoding, default sizing and MMIO status offsets.
package boreal_sched_pkg;

    localparam int BSS_N_STAGES    = 4;
    localparam int BSS_TIMEOUT_CYC = 4096;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LAUNCH = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_FINISH = 3'd3;
    localparam logic [2:0] ST_FAULT  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_LAUNCH = ST_LAUNCH,
        S_WAIT   = ST_WAIT,
        S_FINISH = ST_FINISH,
        S_FAULT  = ST_FAULT
    } sched_state_t;

    // Byte offsets of the status words seen by the MMIO readback block
    localparam logic [7:0] BSS_ADDR_LATENCY = 8'h00;
    localparam logic [7:0] BSS_ADDR_OVERRUN = 8'h04;
    localparam logic [7:0] BSS_ADDR_TIMEOUT = 8'h08;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/boreal_stage_watchdog.sv
// Per-stage watchdog: loadable up-counter with clear and a combinational expiry pulse.
// Expiry fires on the last cycle a stage may still report done without faulting.
module boreal_stage_watchdog
    import boreal_sched_pkg::*;
#(
    parameter int TIMEOUT_CYC = BSS_TIMEOUT_CYC,
    parameter int CW          = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic          clk_50m,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          run,
    output logic          expired
);

    logic [CW-1:0] count;

    always_ff @(posedge clk_50m) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (run && (count != CW'(TIMEOUT_CYC - 1))) begin
            count <= count + CW'(1);
        end
    end

    assign expired = run && (count == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/boreal_stage_scheduler.sv
// Sequences the decode-chain stages per frame with start/done handshakes,
// per-stage watchdog, frame latency capture and dropped-request accounting.
module boreal_stage_scheduler
    import boreal_sched_pkg::*;
#(
    parameter int N_STAGES    = BSS_N_STAGES,
    parameter int TIMEOUT_CYC = BSS_TIMEOUT_CYC,
    parameter int SW          = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
    input  logic                clk_50m,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                frame_req,
    input  logic [N_STAGES-1:0] stage_done,
    input  logic                clear_err,
    output logic [N_STAGES-1:0] stage_start,
    output logic                busy,
    output logic                frame_done,
    output logic [15:0]         latency,
    output logic [7:0]          overrun_cnt,
    output logic                timeout_flag,
    output logic [SW-1:0]       timeout_stage
);

    localparam int                  CW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [N_STAGES-1:0] FIRST = N_STAGES'(1);

    sched_state_t  state;
    logic [SW-1:0] idx;
    logic [SW-1:0] idx_nxt;
    logic [15:0]   lat_cnt;
    logic          wd_expired;
    logic          req_dropped;

    assign idx_nxt     = idx + SW'(1);
    assign req_dropped = frame_req &&
                         ((state == S_LAUNCH) || (state == S_WAIT) || (state == S_FAULT));

    // Loaded with 1 on the start cycle so the count equals cycles elapsed since start
    boreal_stage_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CW          (CW)
    ) u_watchdog (
        .clk_50m  (clk_50m),
        .rst_n    (rst_n),
        .clear    (state == S_IDLE),
        .load     (state == S_LAUNCH),
        .load_val (CW'(1)),
        .run      (state == S_WAIT),
        .expired  (wd_expired)
    );

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            idx           <= '0;
            lat_cnt       <= '0;
            stage_start   <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            latency       <= '0;
            overrun_cnt   <= '0;
            timeout_flag  <= 1'b0;
            timeout_stage <= '0;
        end else begin
            stage_start <= '0;
            frame_done  <= 1'b0;
            if (state != S_IDLE) begin
                lat_cnt <= sat_inc16(lat_cnt);
            end

            case (state)
                // FINISH behaves like IDLE for acceptance so frames can run back-to-back
                S_IDLE, S_FINISH: begin
                    if (frame_req && enable) begin
                        state       <= S_LAUNCH;
                        idx         <= '0;
                        lat_cnt     <= 16'd1;
                        stage_start <= FIRST;
                        busy        <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_LAUNCH: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (stage_done[idx]) begin
                        if (idx == SW'(N_STAGES - 1)) begin
                            state      <= S_FINISH;
                            frame_done <= 1'b1;
                            latency    <= sat_inc16(lat_cnt);
                        end else begin
                            state       <= S_LAUNCH;
                            idx         <= idx_nxt;
                            stage_start <= FIRST << idx_nxt;
                        end
                    end else if (wd_expired) begin
                        state         <= S_FAULT;
                        timeout_flag  <= 1'b1;
                        timeout_stage <= idx;
                    end
                end
                S_FAULT: begin
                    if (clear_err) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Clearing status takes priority over any request dropped in the same cycle
            if (clear_err) begin
                overrun_cnt   <= '0;
                timeout_flag  <= 1'b0;
                timeout_stage <= '0;
            end else if (req_dropped && (overrun_cnt != 8'hFF)) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
        end
    end

endmodule
